// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ser_pkg
//  Description : Shared state encoding and bit-order constants for the
//                parametrised parallel-to-serial converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit-order selector values as seen on msb_first
    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage : ser_pkg
`default_nettype wire

// File: rtl/param_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : param_serializer
//  Description : DATA_WIDTH-bit parallel to serial converter with a one-word
//                holding buffer (valid/ready load), per-word LSB/MSB-first
//                order and gapless back-to-back frames. One bit per ser_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_serializer
    import ser_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_BIT   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active low
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  p_valid,
    output logic                  p_ready,
    input  logic                  msb_first,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_busy,
    output logic                  ser_done
);

    localparam int              CNT_W  = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_q;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_order_q;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_ser_done;

    logic                  w_accept;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_load;

    // p_ready depends only on a register, so p_valid never feeds back into it
    assign w_accept = p_valid && !r_hold_full;
    // ser_en only counts while a word is being shifted
    assign w_tick   = (r_state == ST_SHIFT) && ser_en;
    assign w_last   = w_tick && (r_bit_cnt == C_LAST);
    // Load the shifter from the buffer when idle, or on the final tick so
    // the next word starts without an idle gap
    assign w_load   = r_hold_full && ((r_state == ST_IDLE) || w_last);

    // Next-state decode: leave IDLE when a word is waiting, return only when
    // the final bit goes out with nothing queued behind it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_hold_full)          w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last && !r_hold_full) w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // Holding buffer: capture on handshake, empty when moved into the shifter.
    // Accept and load never coincide because p_ready is low while full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_full <= 1'b0;
            r_hold_q    <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_q    <= p_data;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // FSM state and shifter: order is latched per word so msb_first changes
    // mid-word only affect the next word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_order_q  <= ORDER_LSB;
            r_ser_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ser_done <= w_last;
            if (w_load) begin
                r_shreg   <= r_hold_q;
                r_order_q <= msb_first;
            end else if (w_tick) begin
                if (r_order_q == ORDER_MSB) r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
                else                        r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
            end
        end
    end

    // Bit counter: cleared on every load and on the final tick so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
        end else if (w_load || w_last) begin
            r_bit_cnt <= '0;
        end else if (w_tick) begin
            r_bit_cnt <= r_bit_cnt + C_ONE;
        end
    end

    // Output decode from registers only
    always_comb begin
        p_ready  = !r_hold_full;
        ser_busy = (r_state == ST_SHIFT);
        ser_done = r_ser_done;
        ser_data = IDLE_BIT;
        if (r_state == ST_SHIFT) begin
            ser_data = (r_order_q == ORDER_MSB) ? r_shreg[DATA_WIDTH-1] : r_shreg[0];
        end
    end

endmodule : param_serializer
`default_nettype wire

// File: tb/tb_param_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_serializer
//  Description : Self-checking bench for param_serializer (8- and 12-bit
//                instances) against a queue-based bit-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // 8-bit instance
    logic [7:0]  p_data    = '0;
    logic        p_valid   = 1'b0;
    logic        p_ready;
    logic        msb_first = 1'b0;
    logic        ser_en    = 1'b0;
    logic        ser_data;
    logic        ser_busy;
    logic        ser_done;

    // 12-bit instance
    logic [11:0] d12   = '0;
    logic        v12   = 1'b0;
    logic        rdy12;
    logic        msb12 = 1'b0;
    logic        en12  = 1'b0;
    logic        sd12;
    logic        busy12;
    logic        done12;

    param_serializer #(.DATA_WIDTH(8), .IDLE_BIT(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
        .msb_first(msb_first), .ser_en(ser_en), .ser_data(ser_data),
        .ser_busy(ser_busy), .ser_done(ser_done)
    );

    param_serializer #(.DATA_WIDTH(12), .IDLE_BIT(1'b1)) u_dut12 (
        .clk(clk), .rst(rst), .p_data(d12), .p_valid(v12), .p_ready(rdy12),
        .msb_first(msb12), .ser_en(en12), .ser_data(sd12),
        .ser_busy(busy12), .ser_done(done12)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int en_mode  = 0;   // 0 off, 1 every 4th clk, 2 always, 3 random
    int done_cnt = 0;
    int bitpos   = 0;
    logic exp_done = 1'b0;
    bit   sb[$];        // expected serial bits, oldest first

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Reference: a word expands to DATA_WIDTH bits in the requested order
    task automatic push_bits(input logic [7:0] w, input logic o);
        for (int i = 0; i < 8; i++) sb.push_back(o ? w[7-i] : w[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (en_mode)
            1:       ser_en = (cyc % 4 == 0);
            2:       ser_en = 1'b1;
            3:       ser_en = ($urandom_range(0, 1) == 1);
            default: ser_en = 1'b0;
        endcase
    endtask

    task automatic send_word(input logic [7:0] w, input logic o);
        int n;
        msb_first = o;
        p_data    = w;
        p_valid   = 1'b1;
        n = 0;
        while (!p_ready && n < 300) begin tick(); n++; end
        if (!p_ready) begin
            check("accept_timeout", 32'd1, 32'd0);
            p_valid = 1'b0;
        end else begin
            tick();
            p_valid = 1'b0;
            push_bits(w, o);
        end
    endtask

    task automatic wait_loaded();
        int n = 0;
        while (!p_ready && n < 300) begin tick(); n++; end
        if (!p_ready) check("load_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || ser_busy) && n < 2000) begin tick(); n++; end
        if (sb.size() != 0 || ser_busy) check("drain_timeout", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    // Stream monitor: every consumed bit is compared in order and the done
    // pulse must follow the last bit of each word by one cycle
    always @(negedge clk) begin
        if (!rst) begin
            exp_done = 1'b0;
            bitpos   = 0;
        end else begin
            check("ser_done", ser_done, exp_done);
            if (ser_done) done_cnt++;
            exp_done = 1'b0;
            if (ser_en && ser_busy) begin
                if (sb.size() == 0) check("extra_bit", 32'd1, 32'd0);
                else                check("bit", ser_data, sb.pop_front());
                bitpos++;
                if (bitpos == 8) begin
                    bitpos   = 0;
                    exp_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int gaps;
        int n;
        logic sd0;
        logic [11:0] w12;

        // Reset state
        repeat (3) tick();
        check("rst_ready", p_ready, 1);
        check("rst_busy",  ser_busy, 0);
        check("rst_data",  ser_data, 1);
        check("rst_done",  ser_done, 0);
        rst = 1'b1;
        tick();

        // LSB-first A5
        en_mode = 1;
        d0 = done_cnt;
        send_word(8'hA5, 1'b0);
        drain();
        check("lsb_done_cnt", done_cnt - d0, 1);
        check("lsb_idle_busy", ser_busy, 0);
        check("lsb_idle_data", ser_data, 1);

        // MSB-first A5 then 81
        d0 = done_cnt;
        send_word(8'hA5, 1'b1);
        drain();
        send_word(8'h81, 1'b1);
        drain();
        check("msb_done_cnt", done_cnt - d0, 2);

        // Back-to-back 3C then F0 with no idle gap
        d0 = done_cnt;
        gaps = 0;
        send_word(8'h3C, 1'b0);
        wait_loaded();
        send_word(8'hF0, 1'b0);
        check("b2b_ready_low", p_ready, 0);
        n = 0;
        while (!p_ready && n < 300) begin
            tick();
            n++;
            if (!ser_busy && sb.size() != 0) gaps++;
        end
        check("b2b_reload_q", sb.size(), 8);
        check("b2b_reload_busy", ser_busy, 1);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
            if (!ser_busy && sb.size() != 0) gaps++;
        end
        drain();
        check("b2b_gaps", gaps, 0);
        check("b2b_done_cnt", done_cnt - d0, 2);

        // ser_en pulses while idle: nothing happens
        d0 = done_cnt;
        en_mode = 2;
        repeat (10) tick();
        check("idle_en_busy", ser_busy, 0);
        check("idle_en_done", done_cnt - d0, 0);

        // ser_en held low for 50 clks mid-word: output frozen
        en_mode = 0;
        send_word(8'h5A, 1'b1);
        wait_loaded();
        tick();
        sd0 = ser_data;
        check("stall_first_bit", sd0, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stall_data", ser_data, sd0);
        end
        check("stall_q", sb.size(), 8);
        check("stall_busy", ser_busy, 1);
        en_mode = 1;
        drain();

        // Reset mid-word with a second word in the buffer: both are lost
        send_word(8'hC3, 1'b0);
        wait_loaded();
        send_word(8'h99, 1'b1);
        repeat (6) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_busy",  ser_busy, 0);
        check("mid_rst_data",  ser_data, 1);
        check("mid_rst_ready", p_ready, 1);
        check("mid_rst_done",  ser_done, 0);
        sb.delete();
        tick();
        rst = 1'b1;
        d0 = done_cnt;
        en_mode = 2;
        repeat (20) tick();
        check("post_rst_busy", ser_busy, 0);
        check("post_rst_done", done_cnt - d0, 0);

        // Randomised words, orders and tick patterns
        en_mode = 3;
        d0 = done_cnt;
        for (int k = 0; k < 40; k++) begin
            send_word(8'($urandom), 1'($urandom));
            wait_loaded();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) tick();
        end
        drain();
        check("rand_done_cnt", done_cnt - d0, 40);
        check("rand_sb_empty", sb.size(), 0);

        // 12-bit instance: order toggled mid-word must not affect it
        en_mode = 0;
        tick();
        w12 = 12'hF0F;
        msb12 = 1'b0;
        d12 = w12;
        v12 = 1'b1;
        check("w12_ready", rdy12, 1);
        tick();
        v12 = 1'b0;
        tick();
        check("w12_busy", busy12, 1);
        msb12 = 1'b1;
        en12  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("w12_bit",  sd12, w12[i]);
            check("w12_nodone", done12, 0);
        end
        @(negedge clk);
        check("w12_done", done12, 1);
        check("w12_idle", busy12, 0);
        en12 = 1'b0;
        @(negedge clk);
        check("w12_done_pulse", done12, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_serializer
`default_nettype wire
